// File: rtl/im_loader_pkg.sv
// Shared constants, FSM state encoding and length clamp for the instruction-memory loader.
// The CSUM state exists only when IM_LOADER_CHECKSUM_EN is defined.
package im_loader_pkg;

  localparam int ADDR_W    = 8;
  localparam int INSTR_W   = 16;
  localparam int ADDR_STEP = 2;
  localparam int MAX_WORDS = 128;

`ifdef IM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HI,
    ST_LO,
    ST_WRITE,
    ST_CSUM,
    ST_FIN
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HI,
    ST_LO,
    ST_WRITE,
    ST_FIN
  } state_t;
`endif

  function automatic logic [7:0] clamp_len(input logic [7:0] len, input logic [7:0] max_w);
    return (len > max_w) ? max_w : len;
  endfunction

endpackage

// File: rtl/im_loader_asm.sv
// Big-endian byte-pair assembler: HI byte is parked, LO byte completes the word.
// The assembled word is registered and holds until the next LO capture.
module im_loader_asm #(
  parameter int INSTR_W = 16
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_hi_ld,
  input  logic               i_lo_ld,
  input  logic [7:0]         i_byte,
  output logic [INSTR_W-1:0] o_word
);

  logic [7:0]         r_hi;
  logic [INSTR_W-1:0] r_word;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_hi   <= 8'h00;
      r_word <= '0;
    end else begin
      if (i_hi_ld) begin
        r_hi <= i_byte;
      end
      if (i_lo_ld) begin
        r_word <= INSTR_W'({r_hi, i_byte});
      end
    end
  end

  assign o_word = r_word;

endmodule

// File: rtl/im_loader.sv
// Streams a byte program into instruction memory while holding the CPU in reset.
// Optional trailing checksum byte compiled in with IM_LOADER_CHECKSUM_EN.
module im_loader #(
  parameter int ADDR_W    = im_loader_pkg::ADDR_W,
  parameter int INSTR_W   = im_loader_pkg::INSTR_W,
  parameter int ADDR_STEP = im_loader_pkg::ADDR_STEP,
  parameter int MAX_WORDS = im_loader_pkg::MAX_WORDS
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [7:0]         len_in,
  input  logic [7:0]         byte_in,
  input  logic               byte_valid,
  output logic               byte_ready,
  output logic               im_we,
  output logic [ADDR_W-1:0]  im_addr,
  output logic [INSTR_W-1:0] im_wdata,
  output logic               cpu_hold,
  output logic               busy,
  output logic               done,
  output logic [7:0]         words_loaded,
  output logic               err
);
  import im_loader_pkg::*;

  state_t            r_state;
  state_t            w_next;
  logic [7:0]        r_len;
  logic [7:0]        r_words;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_im_addr;
  logic              w_xfer;
  logic              w_start;
  logic              w_hi_xfer;
  logic              w_lo_xfer;
  logic              w_more;

  assign w_xfer    = byte_valid & byte_ready;
  assign w_start   = (r_state == ST_IDLE) & start;
  assign w_hi_xfer = (r_state == ST_HI) & w_xfer;
  assign w_lo_xfer = (r_state == ST_LO) & w_xfer;
  assign w_more    = (r_words + 8'd1) < r_len;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    byte_ready = 1'b0;
    im_we      = 1'b0;
    done       = 1'b0;
    busy       = 1'b1;
    case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          w_next = (len_in == 8'd0) ? ST_FIN : ST_HI;
        end
      end
      ST_HI: begin
        byte_ready = 1'b1;
        if (w_xfer) w_next = ST_LO;
      end
      ST_LO: begin
        byte_ready = 1'b1;
        if (w_xfer) w_next = ST_WRITE;
      end
      ST_WRITE: begin
        im_we = 1'b1;
`ifdef IM_LOADER_CHECKSUM_EN
        w_next = w_more ? ST_HI : ST_CSUM;
`else
        w_next = w_more ? ST_HI : ST_FIN;
`endif
      end
`ifdef IM_LOADER_CHECKSUM_EN
      ST_CSUM: begin
        byte_ready = 1'b1;
        if (w_xfer) w_next = ST_FIN;
      end
`endif
      ST_FIN: begin
        done   = 1'b1;
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Write address is captured with the LO byte so im_addr is stable through WRITE
  // and holds afterwards while the counter moves on.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_len     <= 8'd0;
      r_words   <= 8'd0;
      r_addr    <= '0;
      r_im_addr <= '0;
    end else begin
      if (w_start) begin
        r_len   <= clamp_len(len_in, 8'(MAX_WORDS));
        r_words <= 8'd0;
        r_addr  <= '0;
      end
      if (w_lo_xfer) begin
        r_im_addr <= r_addr;
      end
      if (r_state == ST_WRITE) begin
        r_addr  <= r_addr + ADDR_W'(ADDR_STEP);
        r_words <= r_words + 8'd1;
      end
    end
  end

  im_loader_asm #(
    .INSTR_W (INSTR_W)
  ) u_asm (
    .i_clk   (clk),
    .i_reset (reset),
    .i_hi_ld (w_hi_xfer),
    .i_lo_ld (w_lo_xfer),
    .i_byte  (byte_in),
    .o_word  (im_wdata)
  );

`ifdef IM_LOADER_CHECKSUM_EN
  logic [7:0] r_sum;
  logic       r_err;
  logic       w_csum_xfer;

  assign w_csum_xfer = (r_state == ST_CSUM) & w_xfer;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sum <= 8'h00;
      r_err <= 1'b0;
    end else begin
      if (w_start) begin
        r_sum <= 8'h00;
        r_err <= 1'b0;
      end else if (w_hi_xfer || w_lo_xfer) begin
        r_sum <= r_sum + byte_in;
      end
      if (w_csum_xfer && (byte_in != r_sum)) begin
        r_err <= 1'b1;
      end
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  assign im_addr      = r_im_addr;
  assign words_loaded = r_words;
  assign cpu_hold     = busy;

endmodule

// File: tb/tb_im_loader.sv
// Directed bench for im_loader: a queue model of expected writes is checked every cycle.
`timescale 1ns/1ps
module tb_im_loader;

`ifdef IM_LOADER_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  len_in = 8'd0;
  logic [7:0]  byte_in = 8'd0;
  logic        byte_ready, im_we, cpu_hold, busy, done, err;
  logic [7:0]  im_addr, words_loaded;
  logic [15:0] im_wdata;

  int n_checks = 0;
  int n_errs   = 0;

  always #5 clk = ~clk;

  im_loader dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .len_in       (len_in),
    .byte_in      (byte_in),
    .byte_valid   (byte_valid),
    .byte_ready   (byte_ready),
    .im_we        (im_we),
    .im_addr      (im_addr),
    .im_wdata     (im_wdata),
    .cpu_hold     (cpu_hold),
    .busy         (busy),
    .done         (done),
    .words_loaded (words_loaded),
    .err          (err)
  );

  typedef struct packed {
    logic [7:0]  a;
    logic [15:0] d;
  } wr_t;

  wr_t        exp_q[$];
  wr_t        e;
  logic [7:0] prog[0:259];
  int         cyc = 0;
  int         done_cnt = 0;
  int         done_cyc = 0;
  int         rdy_cnt = 0;
  int         we_cnt = 0;
  logic [7:0]  last_a = 8'h00;
  logic [15:0] last_d = 16'h0000;
  logic [7:0]  first_a = 8'h00;
  logic [15:0] first_d = 16'h0000;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!reset) begin
      last_a = 8'h00;
      last_d = 16'h0000;
    end else begin
      check("cpu_hold_eq_busy", cpu_hold, busy);
      if (im_we) begin
        we_cnt++;
        if (we_cnt == 1) begin
          first_a = im_addr;
          first_d = im_wdata;
        end
        if (exp_q.size() == 0) begin
          check("unexpected_im_we", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("im_addr", im_addr, e.a);
          check("im_wdata", im_wdata, e.d);
        end
        last_a = im_addr;
        last_d = im_wdata;
      end else begin
        check("addr_hold", im_addr, last_a);
        check("wdata_hold", im_wdata, last_d);
      end
      if (!busy) check("idle_quiet", {byte_ready, im_we, done}, 0);
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (byte_ready) rdy_cnt++;
    end
  end

  task automatic pulse_start(input logic [7:0] len, output int t0);
    @(negedge clk);
    start  = 1'b1;
    len_in = len;
    t0     = cyc;
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic stream(input int nb, input bit toggle);
    int idx = 0;
    int t   = 0;
    while (idx < nb && t < 2000) begin
      byte_in    = prog[idx];
      byte_valid = toggle ? ((t % 2) == 0) : 1'b1;
      #1;
      if (byte_valid && byte_ready) idx++;
      @(negedge clk);
      t++;
    end
    byte_valid = 1'b0;
    check("stream_bytes_taken", idx, nb);
  endtask

  task automatic finish_load(input int t0, input int exp_words, input int exp_lat, input logic exp_err);
    int t = 0;
    while (done_cnt == 0 && t < 600) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    check("done_pulses", done_cnt, 1);
    if (exp_lat > 0) check("load_latency", done_cyc - t0, exp_lat);
    check("words_loaded", words_loaded, exp_words);
    check("pending_writes", exp_q.size(), 0);
    check("err", err, exp_err);
    check("busy_after_done", busy, 0);
  endtask

  // Model: word i lands at 2*i mod 256 as {prog[2i], prog[2i+1]}; checksum is the byte sum.
  task automatic run_load(input int len, input bit toggle, input logic [7:0] delta, output int t0);
    int         eff, nb, lat;
    logic [7:0] sum;
    wr_t        w;
    eff = (len > 128) ? 128 : len;
    sum = 8'h00;
    for (int i = 0; i < eff; i++) begin
      w.a = 8'(2 * i);
      w.d = {prog[2*i], prog[2*i+1]};
      exp_q.push_back(w);
      sum = sum + prog[2*i] + prog[2*i+1];
    end
    nb = 2 * eff;
    if (CS == 1 && eff > 0) begin
      prog[nb] = sum + delta;
      nb++;
    end
    lat = (eff == 0) ? 1 : (3 * eff + 1 + CS);
    done_cnt = 0;
    rdy_cnt  = 0;
    we_cnt   = 0;
    pulse_start(8'(len), t0);
    #1;
    check("err_clear_on_start", err, 0);
    stream(nb, toggle);
    finish_load(t0, eff, toggle ? 0 : lat, (CS == 1 && eff > 0) ? (delta != 8'h00) : 1'b0);
  endtask

  initial begin
    int t0;
    #2 reset = 1'b0;
    #1;
    check("reset_outputs",
          {byte_ready, im_we, cpu_hold, busy, done, err, im_addr, im_wdata, words_loaded}, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    prog[0] = 8'h12; prog[1] = 8'h34; prog[2] = 8'h56; prog[3] = 8'h78;
    run_load(2, 1'b0, 8'h00, t0);
    check("two_word_we_cycles", we_cnt, 2);
    check("first_write", {first_a, first_d}, {8'h00, 16'h1234});
    check("last_write", {last_a, last_d}, {8'h02, 16'h5678});
    check("two_word_latency", done_cyc - t0, (CS == 1) ? 8 : 7);

    prog[0] = 8'hA5; prog[1] = 8'h3C;
    run_load(1, 1'b1, 8'h00, t0);
    check("toggle_we_cycles", we_cnt, 1);
    check("toggle_write", {last_a, last_d}, {8'h00, 16'hA53C});

    run_load(0, 1'b0, 8'h00, t0);
    check("len0_byte_ready", rdy_cnt, 0);
    check("len0_we", we_cnt, 0);
    check("len0_done_latency", done_cyc - t0, 1);

    for (int i = 0; i < 256; i++) prog[i] = 8'(i * 7 + 3);
    run_load(200, 1'b0, 8'h00, t0);
    check("clamp_we_cycles", we_cnt, 128);
    check("clamp_last_addr", last_a, 8'hFE);

`ifdef IM_LOADER_CHECKSUM_EN
    prog[0] = 8'h01; prog[1] = 8'h02;
    run_load(1, 1'b0, 8'h00, t0);
    check("csum_good_err", err, 0);
    prog[0] = 8'h01; prog[1] = 8'h02;
    run_load(1, 1'b0, 8'h01, t0);
    check("csum_bad_err", err, 1);
    prog[0] = 8'h01; prog[1] = 8'h02;
    run_load(1, 1'b0, 8'h00, t0);
`endif

    // Abort after the HI byte of the third word.
    for (int i = 0; i < 8; i++) prog[i] = 8'(8'hC0 + i);
    exp_q.push_back({8'h00, prog[0], prog[1]});
    exp_q.push_back({8'h02, prog[2], prog[3]});
    done_cnt = 0;
    we_cnt   = 0;
    pulse_start(8'd4, t0);
    stream(5, 1'b0);
    #2 reset = 1'b0;
    #1;
    check("abort_outputs_zero",
          {byte_ready, im_we, cpu_hold, busy, done, err, im_addr, im_wdata, words_loaded}, 0);
    check("abort_writes_before", we_cnt, 2);
    start  = 1'b1;
    len_in = 8'd1;
    repeat (2) @(negedge clk);
    #1;
    check("reset_dominates_start", busy, 0);
    check("abort_pending", exp_q.size(), 0);
    check("abort_no_done", done_cnt, 0);
    @(negedge clk);
    reset = 1'b1;
    prog[0] = 8'h9A; prog[1] = 8'hBC; prog[2] = 8'h56;
    exp_q.push_back({8'h00, 16'h9ABC});
    @(negedge clk);
    start = 1'b0;
    #1;
    check("start_after_reset", busy, 1);
    stream(2 + CS, 1'b0);
    finish_load(t0, 1, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/im_loader.md
IM_LOADER -- requirements
Module: im_loader

Interface
REQ-001 Parameters SHALL be:
- ADDR_W, 8, instruction-memory byte-address width.
- INSTR_W, 16, instruction width.
- ADDR_STEP, 2, address increment per instruction.
- MAX_WORDS, 128, maximum instructions per load.

REQ-002 Ports SHALL be:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low (0 = reset).
- start  in  1  single-cycle load request.
- len_in  in  8  instruction count, sampled on accepted start.
- byte_in  in  8  program byte stream.
- byte_valid  in  1  byte_in valid.
- byte_ready  out  1  loader accepts byte.
- im_we  out  1  instruction-memory write strobe.
- im_addr  out  ADDR_W  write byte address.
- im_wdata  out  INSTR_W  write instruction.
- cpu_hold  out  1  holds the CPU pipeline in reset while loading.
- busy  out  1  load in progress.
- done  out  1  one-cycle completion pulse.
- words_loaded  out  8  instructions written this load.
- err  out  1  sticky checksum error.

Function
REQ-003 FSM states SHALL be IDLE, HI, LO, WRITE, CSUM and FIN.
REQ-004 In IDLE, start=1 SHALL latch len_in, clear words_loaded, err and the address counter (8'h00), and go to HI; if len_in=0, it SHALL go directly to FIN.
REQ-005 A byte SHALL transfer only on a rising edge with byte_valid=1 and byte_ready=1; byte_ready SHALL be 1 only in HI, LO and CSUM.
REQ-006 Byte order SHALL be big-endian: the HI byte goes to im_wdata[15:8] (opcode in [15:12]) and the LO byte to [7:0].
REQ-007 Transfer in HI SHALL go to LO; transfer in LO SHALL go to WRITE; without a transfer, the state SHALL hold indefinitely.
REQ-008 In WRITE, im_we SHALL be 1 for exactly one cycle, the cycle after the LO transfer, with im_addr = address counter and im_wdata = assembled word; im_we SHALL be 0 in every other state.
REQ-009 On leaving WRITE, the address SHALL increment by ADDR_STEP modulo 2^ADDR_W (8'hFE -> 8'h00) and words_loaded SHALL increment by 1.
REQ-010 After WRITE, the FSM SHALL go to HI if words_loaded < latched length, else to CSUM (macro defined) or FIN (macro undefined).
REQ-011 len_in > MAX_WORDS SHALL be clamped to MAX_WORDS.
REQ-012 FIN SHALL last one cycle with done=1, then return to IDLE.
REQ-013 busy and cpu_hold SHALL be 1 in every state except IDLE.
REQ-014 start while not in IDLE SHALL be ignored.
REQ-015 im_addr and im_wdata SHALL hold their last values outside WRITE.
REQ-016 Minimum load time SHALL be 3 cycles per instruction with byte_valid held at 1.

Reset
REQ-017 On reset=0, asynchronously: state IDLE; byte_ready, im_we, busy, cpu_hold, done and err = 0; im_addr, im_wdata and words_loaded = 0.
REQ-018 Reset mid-load SHALL abort with no further im_we; the partial load is not resumed.
REQ-019 Reset SHALL dominate a simultaneous start.

Configuration
REQ-020 With IM_LOADER_CHECKSUM_EN defined:
- A running 8-bit sum (mod 256) of all HI and LO bytes SHALL be kept.
- CSUM SHALL accept one byte.
- A mismatch SHALL set err=1, held until the next accepted start.
- The FSM SHALL then go to FIN.
REQ-021 With IM_LOADER_CHECKSUM_EN undefined: no CSUM state and no sum logic; err SHALL be tied to 0.

Structure
REQ-022 Package im_loader_pkg SHALL hold the state enumeration, ADDR_STEP, ADDR_W and INSTR_W constants.
REQ-023 Byte-pair assembly (HI/LO capture into a 16-bit word) SHALL be sub-module im_loader_asm; the FSM, counters and checksum stay in im_loader.

Verification
REQ-024 len_in=2, bytes 12 34 56 78, valid held -> writes (00,1234) and (02,5678), im_we exactly 2 cycles, done pulse, words_loaded=2.
REQ-025 byte_valid toggled 1/0 every cycle during a 1-word load -> same single write, no byte lost or duplicated.
REQ-026 len_in=200 -> exactly 128 writes, addresses 00..FE, counter wraps to 00, done asserted.
REQ-027 reset=0 after the HI byte of word 3 -> no further im_we, all outputs 0 immediately, start accepted next cycle after reset=1.
REQ-028 Macro defined, len_in=1, bytes 01 02, checksum 03 -> err=0; repeat with checksum 04 -> err=1 and done pulse; next start clears err.
REQ-029 len_in=0 -> no byte_ready, no im_we, done pulse 1 cycle after start.
